// File: rtl/cam_cfg_sequencer_if.sv
// rtl/cam_cfg_sequencer_if.sv - init-table ROM and SCCB master handshake bundle
interface cam_cfg_sequencer_if #(
   parameter int ROM_AW = 8
);
   logic [ROM_AW-1:0] o_rom_addr;
   logic [15:0]       i_rom_data;
   logic              o_sccb_start;
   logic [7:0]        o_sccb_reg;
   logic [7:0]        o_sccb_val;
   logic              i_sccb_ready;
   logic              i_sccb_done;
   logic              i_sccb_nack;

   modport master (
      output o_rom_addr,
      input  i_rom_data,
      output o_sccb_start,
      output o_sccb_reg,
      output o_sccb_val,
      input  i_sccb_ready,
      input  i_sccb_done,
      input  i_sccb_nack
   );

   modport slave (
      input  o_rom_addr,
      output i_rom_data,
      input  o_sccb_start,
      input  o_sccb_reg,
      input  o_sccb_val,
      output i_sccb_ready,
      output i_sccb_done,
      output i_sccb_nack
   );
endinterface

// File: rtl/cam_cfg_sequencer.sv
// rtl/cam_cfg_sequencer.sv - walks an OV7670 init table and issues SCCB writes
module cam_cfg_sequencer #(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int ROM_AW      = 8,
   parameter int MAX_RETRY   = 3
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_start,
   cam_cfg_sequencer_if.master bus,
   output logic                o_busy,
   output logic                o_cfg_done,
   output logic                o_error,
   output logic [ROM_AW-1:0]   o_err_addr
);
   localparam int TICK  = CLK_FREQ_HZ / 1000;
   localparam int DLY_W = $clog2(255 * TICK + 1);
   localparam int RW    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [DLY_W-1:0]  TICK_V    = DLY_W'(TICK);
   localparam logic [RW-1:0]     RETRY_MAX = RW'(MAX_RETRY);
   localparam logic [ROM_AW-1:0] LAST_ADDR = '1;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_SEND, S_WAIT, S_DELAY, S_DONE, S_ERR
   } state_t;

   state_t            state_q;
   logic [ROM_AW-1:0] addr_q;
   logic [ROM_AW-1:0] addr_d;
   logic [DLY_W-1:0]  dly_q;
   logic [RW-1:0]     retry_q;
   logic [7:0]        reg_q;
   logic [7:0]        val_q;
   logic              busy_q;
   logic              cfg_done_q;
   logic              error_q;
   logic [ROM_AW-1:0] err_addr_q;

   logic is_end;
   logic is_delay;
   logic advance;

   assign addr_d   = addr_q + ROM_AW'(1);
   assign is_end   = (bus.i_rom_data == 16'hFFFF);
   assign is_delay = (bus.i_rom_data[15:8] == 8'hFE);

   // Every path that moves on to the next table entry funnels through here,
   // so the end-of-ROM check lives in one place instead of wrapping to 0.
   always_comb begin
      advance = 1'b0;
      case (state_q)
         S_DECODE: advance = is_delay && (bus.i_rom_data[7:0] == 8'h00);
         S_DELAY:  advance = (dly_q == '0);
         S_WAIT:   advance = bus.i_sccb_done && !bus.i_sccb_nack;
         default:  advance = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         dly_q      <= '0;
         retry_q    <= '0;
         reg_q      <= '0;
         val_q      <= '0;
         busy_q     <= 1'b0;
         cfg_done_q <= 1'b0;
         error_q    <= 1'b0;
         err_addr_q <= '0;
      end else if (advance) begin
         if (addr_q == LAST_ADDR) begin
            err_addr_q <= addr_q;
            error_q    <= 1'b1;
            state_q    <= S_ERR;
         end else begin
            addr_q  <= addr_d;
            state_q <= S_FETCH;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_start) begin
                  cfg_done_q <= 1'b0;
                  error_q    <= 1'b0;
                  addr_q     <= '0;
                  busy_q     <= 1'b1;
                  state_q    <= S_FETCH;
               end
            end
            S_FETCH: state_q <= S_DECODE;
            S_DECODE: begin
               if (is_end) begin
                  state_q <= S_DONE;
               end else if (is_delay) begin
                  dly_q   <= DLY_W'(bus.i_rom_data[7:0]) * TICK_V - DLY_W'(1);
                  state_q <= S_DELAY;
               end else begin
                  reg_q   <= bus.i_rom_data[15:8];
                  val_q   <= bus.i_rom_data[7:0];
                  retry_q <= '0;
                  state_q <= S_SEND;
               end
            end
            S_SEND: begin
               if (bus.i_sccb_ready) state_q <= S_WAIT;
            end
            S_WAIT: begin
               // Only the NACK outcome reaches here; ACK is handled by advance.
               if (bus.i_sccb_done) begin
                  if (retry_q < RETRY_MAX) begin
                     retry_q <= retry_q + RW'(1);
                     state_q <= S_SEND;
                  end else begin
                     err_addr_q <= addr_q;
                     error_q    <= 1'b1;
                     state_q    <= S_ERR;
                  end
               end
            end
            S_DELAY: dly_q <= dly_q - DLY_W'(1);
            S_DONE: begin
               cfg_done_q <= 1'b1;
               busy_q     <= 1'b0;
               state_q    <= S_IDLE;
            end
            S_ERR: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Start is gated by ready directly so the first write can go out 3 cycles after i_start.
   assign bus.o_sccb_start = (state_q == S_SEND) && bus.i_sccb_ready;
   assign bus.o_rom_addr   = addr_q;
   assign bus.o_sccb_reg   = reg_q;
   assign bus.o_sccb_val   = val_q;
   assign o_busy           = busy_q;
   assign o_cfg_done       = cfg_done_q;
   assign o_error          = error_q;
   assign o_err_addr       = err_addr_q;
endmodule
